// File: rtl/loop_detect_engine.sv
// loop_detect_engine: collects directed edges into an N x N reachability matrix, closes it with
// Warshall's algorithm one row per cycle, then reports whether any node reaches itself.
module loop_detect_engine #(
   parameter int N   = 16,
   parameter int IDW = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           edge_valid,
   output logic           edge_ready,
   input  logic [IDW-1:0] edge_src,
   input  logic [IDW-1:0] edge_dst,
   input  logic           edge_last,
   output logic           busy,
   output logic           done,
   output logic           loop_found,
   output logic [IDW-1:0] loop_node,
   output logic           bad_edge
);

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      CLOSE = 2'd1,
      SCAN  = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [IDW-1:0] LAST_ID = IDW'(N - 1);
   localparam logic [IDW:0]   N_EXT   = (IDW + 1)'(N);

   state_t           state_r;
   logic [N-1:0]     mat_r [N];
   logic [IDW-1:0]   k_r;
   logic [IDW-1:0]   i_r;
   logic             edge_ready_r;
   logic             busy_r;
   logic             done_r;
   logic             loop_found_r;
   logic [IDW-1:0]   loop_node_r;
   logic             bad_edge_r;

   logic             accept_s;
   logic             in_range_s;
   logic [N-1:0]     onehot_s;
   logic [N-1:0]     diag_s;
   logic             any_s;
   logic [IDW-1:0]   low_s;

   assign edge_ready = edge_ready_r;
   assign busy       = busy_r;
   assign done       = done_r;
   assign loop_found = loop_found_r;
   assign loop_node  = loop_node_r;
   assign bad_edge   = bad_edge_r;

   // Edge acceptance, range check and one-hot column for the destination node
   always_comb begin
      accept_s   = edge_valid && edge_ready_r;
      in_range_s = ({1'b0, edge_src} < N_EXT) && ({1'b0, edge_dst} < N_EXT);
      onehot_s   = {{(N - 1){1'b0}}, 1'b1} << edge_dst;
   end

   // Diagonal of the closed matrix; descending scan leaves the lowest cyclic node in low_s
   always_comb begin
      diag_s = '0;
      low_s  = '0;
      for (int j = 0; j < N; j++) begin
         diag_s[j] = mat_r[j][j];
      end
      for (int j = N - 1; j >= 0; j--) begin
         if (diag_s[j]) begin
            low_s = IDW'(j);
         end else begin
            low_s = low_s;
         end
      end
      any_s = |diag_s;
   end

   // Main FSM: edge loading, row-per-cycle closure, diagonal scan, result hold
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r      <= LOAD;
         for (int r = 0; r < N; r++) begin
            mat_r[r] <= '0;
         end
         k_r          <= '0;
         i_r          <= '0;
         edge_ready_r <= 1'b1;
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
         loop_found_r <= 1'b0;
         loop_node_r  <= '0;
         bad_edge_r   <= 1'b0;
      end else begin
         case (state_r)
            LOAD: begin
               if (accept_s) begin
                  if (in_range_s) begin
                     mat_r[edge_src][edge_dst] <= 1'b1;
                  end else begin
                     bad_edge_r <= 1'b1;
                  end
                  if (edge_last) begin
                     state_r      <= CLOSE;
                     k_r          <= '0;
                     i_r          <= '0;
                     edge_ready_r <= 1'b0;
                     busy_r       <= 1'b1;
                  end
               end
            end
            CLOSE: begin
               // Row i absorbs row k when i already reaches k
               if (mat_r[i_r][k_r]) begin
                  mat_r[i_r] <= mat_r[i_r] | mat_r[k_r];
               end
               if (i_r == LAST_ID) begin
                  i_r <= '0;
                  if (k_r == LAST_ID) begin
                     state_r <= SCAN;
                  end else begin
                     k_r <= k_r + IDW'(1);
                  end
               end else begin
                  i_r <= i_r + IDW'(1);
               end
            end
            SCAN: begin
               loop_found_r <= any_s;
               loop_node_r  <= low_s;
               done_r       <= 1'b1;
               busy_r       <= 1'b0;
               edge_ready_r <= 1'b1;
               state_r      <= DONE;
            end
            DONE: begin
               // First edge of the next graph wipes the matrix and lands in the same cycle
               if (accept_s) begin
                  for (int r = 0; r < N; r++) begin
                     mat_r[r] <= (in_range_s && (edge_src == IDW'(r))) ? onehot_s : '0;
                  end
                  bad_edge_r   <= !in_range_s;
                  done_r       <= 1'b0;
                  loop_found_r <= 1'b0;
                  loop_node_r  <= '0;
                  if (edge_last) begin
                     state_r      <= CLOSE;
                     k_r          <= '0;
                     i_r          <= '0;
                     edge_ready_r <= 1'b0;
                     busy_r       <= 1'b1;
                  end else begin
                     state_r <= LOAD;
                  end
               end
            end
            default: begin
               state_r <= LOAD;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_loop_detect_engine.sv
// Self-checking bench for loop_detect_engine: directed and random graphs on N=16 and N=12
// instances, compared against a breadth-first-search cycle model.
module tb_loop_detect_engine;

   logic       clk;
   logic       rst;
   logic       edge_valid;
   logic [3:0] edge_src;
   logic [3:0] edge_dst;
   logic       edge_last;
   bit         sel16;

   logic       r16, b16, d16, f16, e16;
   logic [3:0] n16;
   logic       r12, b12, d12, f12, e12;
   logic [3:0] n12;

   logic       o_ready, o_busy, o_done, o_found, o_bad;
   logic [3:0] o_node;

   int checks = 0;
   int errors = 0;

   bit adj [16][16];
   bit mbad;
   bit newgraph;

   loop_detect_engine #(.N(16), .IDW(4)) u16 (
      .clk(clk), .rst(rst), .edge_valid(edge_valid & sel16), .edge_ready(r16),
      .edge_src(edge_src), .edge_dst(edge_dst), .edge_last(edge_last),
      .busy(b16), .done(d16), .loop_found(f16), .loop_node(n16), .bad_edge(e16)
   );

   loop_detect_engine #(.N(12), .IDW(4)) u12 (
      .clk(clk), .rst(rst), .edge_valid(edge_valid & ~sel16), .edge_ready(r12),
      .edge_src(edge_src), .edge_dst(edge_dst), .edge_last(edge_last),
      .busy(b12), .done(d12), .loop_found(f12), .loop_node(n12), .bad_edge(e12)
   );

   assign o_ready = sel16 ? r16 : r12;
   assign o_busy  = sel16 ? b16 : b12;
   assign o_done  = sel16 ? d16 : d12;
   assign o_found = sel16 ? f16 : f12;
   assign o_node  = sel16 ? n16 : n12;
   assign o_bad   = sel16 ? e16 : e12;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int ncur();
      return sel16 ? 16 : 12;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      for (int a = 0; a < 16; a++)
         for (int b = 0; b < 16; b++)
            adj[a][b] = 1'b0;
      mbad = 1'b0;
   endtask

   // node j is cyclic iff a search over edges starting at j comes back to j
   function automatic void model_eval(input int n, output bit found, output int node);
      found = 1'b0;
      node  = 0;
      for (int j = n - 1; j >= 0; j--) begin
         bit seen [16];
         int q[$];
         int v;
         foreach (seen[x]) seen[x] = 1'b0;
         q.push_back(j);
         while (q.size() > 0) begin
            v = q.pop_front();
            for (int w = 0; w < n; w++) begin
               if (adj[v][w] && !seen[w]) begin
                  seen[w] = 1'b1;
                  q.push_back(w);
               end
            end
         end
         if (seen[j]) begin
            found = 1'b1;
            node  = j;
         end
      end
   endfunction

   task automatic send_edge(input int s, input int d, input bit last);
      int n = 0;
      @(negedge clk);
      edge_valid = 1'b1;
      edge_src   = 4'(s);
      edge_dst   = 4'(d);
      edge_last  = last;
      while (o_ready !== 1'b1 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 2000) begin
         chk("ready_timeout", 64'(o_ready), 64'd1);
         edge_valid = 1'b0;
      end else begin
         @(posedge clk);
         #1;
         edge_valid = 1'b0;
         if (newgraph) model_clear();
         newgraph = 1'b0;
         if (s < ncur() && d < ncur()) adj[s][d] = 1'b1;
         else mbad = 1'b1;
         if (last) newgraph = 1'b1;
      end
   endtask

   task automatic send_graph(input int s[$], input int d[$]);
      foreach (s[x]) send_edge(s[x], d[x], x == s.size() - 1);
   endtask

   task automatic finish_graph(input string tag);
      int n = 0;
      bit f;
      int nd;
      while (n < 5000) begin
         @(negedge clk);
         n++;
         if (n == 1) chk({tag, "_busy"}, 64'(o_busy), 64'd1);
         if (o_done === 1'b1) break;
      end
      chk({tag, "_latency"}, 64'(n), 64'(ncur() * ncur() + 2));
      model_eval(ncur(), f, nd);
      chk({tag, "_found"}, 64'(o_found), 64'(f));
      chk({tag, "_node"},  64'(o_node),  64'(nd));
      chk({tag, "_bad"},   64'(o_bad),   64'(mbad));
      chk({tag, "_idle"},  64'(o_busy),  64'd0);
      chk({tag, "_ready"}, 64'(o_ready), 64'd1);
   endtask

   task automatic random_graph(input string tag, input int maxid);
      int ne;
      int s[$];
      int d[$];
      ne = $urandom_range(1, 10);
      for (int x = 0; x < ne; x++) begin
         s.push_back($urandom_range(0, maxid));
         d.push_back($urandom_range(0, maxid));
      end
      send_graph(s, d);
      finish_graph(tag);
   endtask

   initial begin
      bit f;
      int nd;
      rst        = 1'b1;
      edge_valid = 1'b0;
      edge_src   = 4'd0;
      edge_dst   = 4'd0;
      edge_last  = 1'b0;
      sel16      = 1'b1;
      newgraph   = 1'b1;
      model_clear();
      repeat (3) @(negedge clk);
      chk("rst_ready", 64'(o_ready), 64'd1);
      chk("rst_busy",  64'(o_busy),  64'd0);
      chk("rst_done",  64'(o_done),  64'd0);
      chk("rst_found", 64'(o_found), 64'd0);
      chk("rst_node",  64'(o_node),  64'd0);
      chk("rst_bad",   64'(o_bad),   64'd0);
      chk("rst_done12", 64'(d12),    64'd0);
      rst = 1'b0;

      send_graph('{0, 1, 2, 3, 4, 5, 6, 7, 8}, '{1, 2, 3, 4, 5, 6, 7, 8, 0});
      finish_graph("ring");
      chk("ring_found_const", 64'(o_found), 64'd1);
      chk("ring_node_const",  64'(o_node),  64'd0);
      send_graph('{0, 1, 2, 3, 4, 5, 6, 7, 1, 10}, '{1, 2, 3, 4, 5, 6, 7, 8, 10, 11});
      finish_graph("chain_fanout");
      chk("chain_found_const", 64'(o_found), 64'd0);
      send_graph('{3, 4, 5}, '{4, 6, 5});
      finish_graph("selfloop");
      chk("selfloop_node_const", 64'(o_node), 64'd5);
      send_graph('{2, 3, 4, 4, 7, 9}, '{3, 4, 2, 7, 9, 4});
      finish_graph("nested");
      chk("nested_node_const", 64'(o_node), 64'd2);
      for (int g = 0; g < 6; g++) random_graph($sformatf("rand16_%0d", g), 9);

      sel16    = 1'b0;
      newgraph = 1'b1;
      send_edge(13, 2, 1'b0);
      chk("bad_sticky_load", 64'(o_bad), 64'd1);
      send_edge(1, 1, 1'b1);
      finish_graph("n12_bad");
      chk("n12_bad_const",  64'(o_bad),  64'd1);
      chk("n12_node_const", 64'(o_node), 64'd1);
      send_edge(0, 1, 1'b1);
      chk("n12_newgraph_done_clr", 64'(o_done), 64'd0);
      finish_graph("n12_clean");
      chk("n12_clean_bad_const", 64'(o_bad), 64'd0);
      for (int g = 0; g < 6; g++) random_graph($sformatf("rand12_%0d", g), 13);

      sel16    = 1'b1;
      newgraph = 1'b1;
      send_graph('{0, 1, 2, 3, 4, 5, 6, 7, 8}, '{1, 2, 3, 4, 5, 6, 7, 8, 0});
      edge_valid = 1'b1;
      edge_src   = 4'd5;
      edge_dst   = 4'd5;
      edge_last  = 1'b1;
      for (int c = 1; c <= 100; c++) begin
         @(negedge clk);
         if (c == 50) begin
            chk("close_ready", 64'(o_ready), 64'd0);
            chk("close_busy",  64'(o_busy),  64'd1);
         end
      end
      edge_valid = 1'b0;
      rst        = 1'b1;
      #1;
      chk("midrst_busy",  64'(o_busy),  64'd0);
      chk("midrst_done",  64'(o_done),  64'd0);
      chk("midrst_found", 64'(o_found), 64'd0);
      chk("midrst_node",  64'(o_node),  64'd0);
      chk("midrst_bad",   64'(o_bad),   64'd0);
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_ready", 64'(o_ready), 64'd1);
      model_clear();
      newgraph = 1'b1;
      send_edge(0, 1, 1'b1);
      finish_graph("after_rst");
      model_eval(16, f, nd);
      chk("after_rst_found_const", 64'(o_found), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
